oc_collector_slot: RTL and testbench

//  Parametrised operand-collector slot: holds one issued instruction, gathers up to NUM_SRC

---
 rtl/oc_pkg.sv | 27 ++
 rtl/oc_collector_slot_if.sv | 47 ++++
 rtl/oc_bank_match.sv | 48 ++++
 rtl/oc_collector_slot.sv | 159 +++++++++++++++
 tb/tb_oc_collector_slot.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/oc_pkg.sv
// Package for the operand-collector slot: FSM state encoding, tag helper and
// width helpers shared by the slot, its bank matcher and its interface.
// Optional feature macro used by the slot: OC_SPE_BYPASS_EN.
package oc_pkg;

  typedef enum logic [1:0] {
    OC_IDLE    = 2'd0,
    OC_COLLECT = 2'd1,
    OC_READY   = 2'd2
  } oc_state_e;

  // Bank index width; never below one bit so a single-bank build still has a field.
  function automatic int oc_bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  // Tag width needed to name every source of every slot in the array.
  function automatic int oc_tag_w(input int num_slots, input int num_src);
    return oc_bank_w(num_slots * num_src);
  endfunction

  // Bank-response tag that addresses source `src` of slot `ocid`.
  function automatic int oc_tag(input int ocid, input int src, input int num_src = 3);
    return ocid * num_src + src;
  endfunction

endpackage

// File: rtl/oc_collector_slot_if.sv
// Bundle of all non-clock signals of one operand-collector slot.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid
// never depends combinationally on ready, and data is held while valid && !ready.
interface oc_collector_slot_if #(
  parameter int NUM_BANKS = 4,
  parameter int NUM_SRC   = 3,
  parameter int DATA_W    = 256,
  parameter int TAG_W     = 4,
  parameter int PAYLOAD_W = 64
) ();
  localparam int BANK_W = oc_pkg::oc_bank_w(NUM_BANKS);

  logic                          alloc_valid;
  logic                          alloc_ready;
  logic [NUM_SRC-1:0]            alloc_src_vld;
  logic [NUM_SRC*BANK_W-1:0]     alloc_src_bank;
  logic [PAYLOAD_W-1:0]          alloc_payload;
  logic [NUM_SRC-1:0]            bypass_vld;
  logic [NUM_SRC*DATA_W-1:0]     bypass_data;
  logic [NUM_BANKS-1:0]          bk_vld;
  logic [NUM_BANKS-1:0]          bk_bz;
  logic [NUM_BANKS*TAG_W-1:0]    bk_tag;
  logic [NUM_BANKS*DATA_W-1:0]   bk_data;
  logic                          flush;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_SRC*DATA_W-1:0]     out_data;
  logic [PAYLOAD_W-1:0]          out_payload;
  logic [NUM_SRC-1:0]            pending_mask;
  logic                          tag_conflict;
  logic [1:0]                    dbg_state;

  // Allocator / bank arbiter / execute side.
  modport master (
    output alloc_valid, alloc_src_vld, alloc_src_bank, alloc_payload,
    output bypass_vld, bypass_data, bk_vld, bk_bz, bk_tag, bk_data, flush, out_ready,
    input  alloc_ready, out_valid, out_data, out_payload, pending_mask, tag_conflict, dbg_state
  );

  // The collector slot itself.
  modport slave (
    input  alloc_valid, alloc_src_vld, alloc_src_bank, alloc_payload,
    input  bypass_vld, bypass_data, bk_vld, bk_bz, bk_tag, bk_data, flush, out_ready,
    output alloc_ready, out_valid, out_data, out_payload, pending_mask, tag_conflict, dbg_state
  );

endinterface

// File: rtl/oc_bank_match.sv
// Per-source match of all bank responses: finds the lowest-index bank whose
// response carries this source's tag, reports whether that bank is the one the
// source expects, and flags when more than one bank carried the tag.
module oc_bank_match #(
  parameter int               NUM_BANKS = 4,
  parameter int               TAG_W     = 4,
  parameter int               BANK_W    = 2,
  parameter logic [TAG_W-1:0] MATCH_TAG = '0
) (
  input  logic [NUM_BANKS-1:0]       bk_vld_i,
  input  logic [NUM_BANKS-1:0]       bk_bz_i,
  input  logic [NUM_BANKS*TAG_W-1:0] bk_tag_i,
  input  logic [BANK_W-1:0]          exp_bank_i,
  output logic                       hit_o,
  output logic [BANK_W-1:0]          hit_bank_o,
  output logic                       conflict_o
);

  logic [NUM_BANKS-1:0] cand;
  logic                 found;

  // A bank is a candidate when it returns valid, non-busy data with our tag.
  always_comb begin
    cand = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      cand[b] = bk_vld_i[b] && !bk_bz_i[b] && (bk_tag_i[b*TAG_W +: TAG_W] == MATCH_TAG);
    end
  end

  // Lowest-index candidate wins; any further candidate marks a conflict.
  always_comb begin
    found      = 1'b0;
    conflict_o = 1'b0;
    hit_bank_o = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (cand[b]) begin
        if (found) begin
          conflict_o = 1'b1;
        end else begin
          found      = 1'b1;
          hit_bank_o = BANK_W'(b);
        end
      end
    end
    hit_o = found && (hit_bank_o == exp_bank_i);
  end

endmodule

// File: rtl/oc_collector_slot.sv
// Operand-collector slot: holds one issued instruction, gathers its source
// operands from register-file bank responses (or bypass), then offers the
// bundle to execute with valid/ready.
// Optional feature: define OC_SPE_BYPASS_EN to let bypass writes also fill
// outstanding sources while collecting (bypass beats a same-cycle bank hit).
module oc_collector_slot
  import oc_pkg::*;
#(
  parameter int OCID      = 0,
  parameter int NUM_BANKS = 4,
  parameter int NUM_SRC   = 3,
  parameter int DATA_W    = 256,
  parameter int TAG_W     = 4,
  parameter int PAYLOAD_W = 64
) (
  input logic               clk,
  input logic               rst_n,
  oc_collector_slot_if.slave bus
);

  localparam int BANK_W = oc_bank_w(NUM_BANKS);

  oc_state_e            state_q, state_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [BANK_W-1:0]    bank_q [NUM_SRC];
  logic [BANK_W-1:0]    bank_d [NUM_SRC];
  logic [DATA_W-1:0]    data_q [NUM_SRC];
  logic [DATA_W-1:0]    data_d [NUM_SRC];
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 conflict_q, conflict_d;

  logic [NUM_SRC-1:0]   hit;
  logic [NUM_SRC-1:0]   conflict;
  logic [BANK_W-1:0]    hit_bank [NUM_SRC];
  logic [NUM_SRC-1:0]   byp_live;
  logic                 alloc_fire;
  logic                 out_fire;
  logic [NUM_SRC*DATA_W-1:0] out_data_w;

  // One matcher per source, each watching for its own tag.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_match
    localparam logic [TAG_W-1:0] SRC_TAG = TAG_W'(oc_tag(OCID, s, NUM_SRC));
    oc_bank_match #(
      .NUM_BANKS (NUM_BANKS),
      .TAG_W     (TAG_W),
      .BANK_W    (BANK_W),
      .MATCH_TAG (SRC_TAG)
    ) u_match (
      .bk_vld_i   (bus.bk_vld),
      .bk_bz_i    (bus.bk_bz),
      .bk_tag_i   (bus.bk_tag),
      .exp_bank_i (bank_q[s]),
      .hit_o      (hit[s]),
      .hit_bank_o (hit_bank[s]),
      .conflict_o (conflict[s])
    );
  end

`ifdef OC_SPE_BYPASS_EN
  assign byp_live = bus.bypass_vld;
`else
  assign byp_live = '0;
`endif

  // Flush blocks allocation so a kill never races a new instruction in.
  assign bus.alloc_ready = !bus.flush &&
                           ((state_q == OC_IDLE) || ((state_q == OC_READY) && bus.out_ready));
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
  assign out_fire        = (state_q == OC_READY) && bus.out_ready;

  // Next-state: flush, then allocation (incl. back-to-back), then collection / drain.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    payload_d  = payload_q;
    conflict_d = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      bank_d[s] = bank_q[s];
      data_d[s] = data_q[s];
    end
    if (bus.flush) begin
      state_d   = OC_IDLE;
      pending_d = '0;
    end else if (alloc_fire) begin
      payload_d = bus.alloc_payload;
      pending_d = bus.alloc_src_vld & ~bus.bypass_vld;
      for (int s = 0; s < NUM_SRC; s++) begin
        bank_d[s] = bus.alloc_src_bank[s*BANK_W +: BANK_W];
        if (bus.alloc_src_vld[s] && bus.bypass_vld[s]) begin
          data_d[s] = bus.bypass_data[s*DATA_W +: DATA_W];
        end else begin
          data_d[s] = '0;
        end
      end
      state_d = (pending_d != '0) ? OC_COLLECT : OC_READY;
    end else if (state_q == OC_COLLECT) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (pending_q[s]) begin
          if (byp_live[s]) begin
            data_d[s]    = bus.bypass_data[s*DATA_W +: DATA_W];
            pending_d[s] = 1'b0;
          end else begin
            if (hit[s]) begin
              data_d[s]    = bus.bk_data[int'(hit_bank[s])*DATA_W +: DATA_W];
              pending_d[s] = 1'b0;
            end
            if (conflict[s]) begin
              conflict_d = 1'b1;
            end
          end
        end
      end
      if (pending_d == '0) begin
        state_d = OC_READY;
      end
    end else if (out_fire) begin
      state_d = OC_IDLE;
    end
  end

  // State and operand registers; async reset clears any partial collection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OC_IDLE;
      pending_q  <= '0;
      payload_q  <= '0;
      conflict_q <= 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
        bank_q[s] <= '0;
        data_q[s] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      payload_q  <= payload_d;
      conflict_q <= conflict_d;
      for (int s = 0; s < NUM_SRC; s++) begin
        bank_q[s] <= bank_d[s];
        data_q[s] <= data_d[s];
      end
    end
  end

  // Pack per-source operand registers onto the output bus.
  always_comb begin
    out_data_w = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      out_data_w[s*DATA_W +: DATA_W] = data_q[s];
    end
  end

  assign bus.out_valid    = (state_q == OC_READY);
  assign bus.out_data     = out_data_w;
  assign bus.out_payload  = payload_q;
  assign bus.pending_mask = pending_q;
  assign bus.tag_conflict = conflict_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_oc_collector_slot.sv
// Directed bench for oc_collector_slot (OCID=1, 4 banks, 3 sources, 32-bit operands).
module tb_oc_collector_slot;
  import oc_pkg::*;

  localparam int OCID = 1;
  localparam int NB   = 4;
  localparam int NS   = 3;
  localparam int DW   = 32;
  localparam int TW   = 4;
  localparam int PW   = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oc_collector_slot_if #(.NUM_BANKS(NB), .NUM_SRC(NS), .DATA_W(DW), .TAG_W(TW), .PAYLOAD_W(PW)) bus ();

  oc_collector_slot #(
    .OCID(OCID), .NUM_BANKS(NB), .NUM_SRC(NS), .DATA_W(DW), .TAG_W(TW), .PAYLOAD_W(PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [NS*DW-1:0] exp_q[$];
  logic [NS*DW-1:0] exp_data;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.alloc_valid    = 1'b0;
    bus.alloc_src_vld  = '0;
    bus.alloc_src_bank = '0;
    bus.alloc_payload  = '0;
    bus.bypass_vld     = '0;
    bus.bypass_data    = '0;
    bus.bk_vld         = '0;
    bus.bk_bz          = '0;
    bus.bk_tag         = '0;
    bus.bk_data        = '0;
    bus.flush          = 1'b0;
    bus.out_ready      = 1'b0;
  endtask

  task automatic alloc(input logic [NS-1:0] src_vld, input logic [5:0] banks, input logic [PW-1:0] pl);
    bus.alloc_valid    = 1'b1;
    bus.alloc_src_vld  = src_vld;
    bus.alloc_src_bank = banks;
    bus.alloc_payload  = pl;
  endtask

  task automatic bank(input int b, input logic [TW-1:0] tag, input logic [DW-1:0] d, input logic bz);
    bus.bk_vld[b]             = 1'b1;
    bus.bk_bz[b]              = bz;
    bus.bk_tag[b*TW +: TW]    = tag;
    bus.bk_data[b*DW +: DW]   = d;
  endtask

  // Watchdog: the directed sequence is short; anything this long is a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_pending",   bus.pending_mask, 0);
    check("rst_out_data",  bus.out_data, 0);
    check("rst_payload",   bus.out_payload, 0);
    check("rst_conflict",  bus.tag_conflict, 0);
    check("rst_state",     bus.dbg_state, OC_IDLE);
    rst_n = 1'b1;
    #1;
    check("rst_alloc_ready", bus.alloc_ready, 1);

    // 1: two sources from banks 2 and 1, hits arrive on separate cycles.
    alloc(3'b011, 6'b00_01_10, 16'hA1A1);
    step();
    clear_inputs();
    check("t1_state_collect", bus.dbg_state, OC_COLLECT);
    check("t1_pending0", bus.pending_mask, 3'b011);
    bank(1, 4'd4, 32'h1111_0001, 1'b0);
    step();
    clear_inputs();
    check("t1_pending1", bus.pending_mask, 3'b001);
    check("t1_not_valid", bus.out_valid, 0);
    bank(2, 4'd3, 32'h2222_0002, 1'b0);
    step();
    clear_inputs();
    check("t1_valid", bus.out_valid, 1);
    check("t1_pending2", bus.pending_mask, 0);
    check("t1_data", bus.out_data, {32'h0, 32'h1111_0001, 32'h2222_0002});
    check("t1_payload", bus.out_payload, 16'hA1A1);
    bus.out_ready = 1'b1;
    #1;
    check("t1_alloc_ready_drain", bus.alloc_ready, 1);
    step();
    clear_inputs();
    check("t1_idle", bus.dbg_state, OC_IDLE);
    check("t1_valid_drop", bus.out_valid, 0);

    // 2: no sources needed -> ready next cycle, held stable under backpressure.
    alloc(3'b000, 6'b0, 16'hB2B2);
    exp_q.push_back('0);
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      check("t2_valid", bus.out_valid, 1);
      check("t2_data", bus.out_data, exp_q[0]);
      check("t2_payload", bus.out_payload, 16'hB2B2);
      check("t2_alloc_ready_blocked", bus.alloc_ready, 0);
      step();
    end
    exp_data = exp_q.pop_front();

    // 3: drain and reload on the same edge; src2 supplied by alloc-cycle bypass.
    bus.out_ready = 1'b1;
    alloc(3'b100, 6'b0, 16'hC3C3);
    bus.bypass_vld = 3'b100;
    bus.bypass_data[2*DW +: DW] = 32'hCCCC_0003;
    exp_q.push_back({32'hCCCC_0003, 32'h0, 32'h0});
    #1;
    check("t3_alloc_ready", bus.alloc_ready, 1);
    step();
    clear_inputs();
    check("t3_valid_no_bubble", bus.out_valid, 1);
    check("t3_payload", bus.out_payload, 16'hC3C3);
    exp_data = exp_q.pop_front();
    check("t3_data", bus.out_data, exp_data);
    bus.out_ready = 1'b1;
    step();
    clear_inputs();
    check("t3_idle", bus.dbg_state, OC_IDLE);

    // 4: wrong bank and busy bank ignored; two banks on one tag -> bank0 wins.
    alloc(3'b001, 6'b00_00_00, 16'hD4D4);
    step();
    clear_inputs();
    bank(1, 4'd3, 32'hBAD0_0001, 1'b0);
    step();
    clear_inputs();
    check("t4_wrong_bank", bus.pending_mask, 3'b001);
    check("t4_wrong_bank_conf", bus.tag_conflict, 0);
    bank(0, 4'd3, 32'hBAD0_0002, 1'b1);
    step();
    clear_inputs();
    check("t4_busy_bank", bus.pending_mask, 3'b001);
    bank(0, 4'd3, 32'hE000_0000, 1'b0);
    bank(3, 4'd3, 32'hE000_0003, 1'b0);
    step();
    clear_inputs();
    check("t4_pending", bus.pending_mask, 0);
    check("t4_conflict", bus.tag_conflict, 1);
    check("t4_data", bus.out_data, {32'h0, 32'h0, 32'hE000_0000});
    bus.out_ready = 1'b1;
    step();
    clear_inputs();
    check("t4_conflict_pulse", bus.tag_conflict, 0);
    check("t4_idle", bus.dbg_state, OC_IDLE);

    // 5: non-pending hit ignored, flush, flush-vs-alloc, late hit, async reset.
    alloc(3'b101, 6'b11_00_01, 16'hE5E5);
    step();
    clear_inputs();
    check("t5_pending", bus.pending_mask, 3'b101);
    bank(0, 4'd4, 32'hBAD0_0004, 1'b0);
    step();
    clear_inputs();
    check("t5_nonpending_mask", bus.pending_mask, 3'b101);
    check("t5_nonpending_data", bus.out_data, 0);
    bus.flush = 1'b1;
    step();
    clear_inputs();
    check("t5_flush_state", bus.dbg_state, OC_IDLE);
    check("t5_flush_pending", bus.pending_mask, 0);
    check("t5_flush_valid", bus.out_valid, 0);
    bus.flush = 1'b1;
    alloc(3'b000, 6'b0, 16'hF0F0);
    #1;
    check("t5_flush_blocks_alloc", bus.alloc_ready, 0);
    step();
    clear_inputs();
    check("t5_flush_alloc_state", bus.dbg_state, OC_IDLE);
    check("t5_flush_alloc_valid", bus.out_valid, 0);
    bank(1, 4'd3, 32'hBAD0_0005, 1'b0);
    step();
    clear_inputs();
    check("t5_late_hit", bus.dbg_state, OC_IDLE);
    check("t5_late_hit_valid", bus.out_valid, 0);
    alloc(3'b010, 6'b00_10_00, 16'h5E5E);
    step();
    clear_inputs();
    check("t5_pre_reset_payload", bus.out_payload, 16'h5E5E);
    rst_n = 1'b0;
    #2;
    check("t5_async_payload", bus.out_payload, 0);
    check("t5_async_pending", bus.pending_mask, 0);
    check("t5_async_state", bus.dbg_state, OC_IDLE);
    check("t5_async_valid", bus.out_valid, 0);
    step();
    rst_n = 1'b1;
    step();

    // 6: bypass and bank hit on the same pending source during collection.
    alloc(3'b010, 6'b00_10_00, 16'h6666);
    step();
    clear_inputs();
    bus.bypass_vld = 3'b010;
    bus.bypass_data[1*DW +: DW] = 32'hBBBB_0001;
    bank(2, 4'd4, 32'hAAAA_0002, 1'b0);
    step();
    clear_inputs();
`ifdef OC_SPE_BYPASS_EN
    exp_data = {32'h0, 32'hBBBB_0001, 32'h0};
`else
    exp_data = {32'h0, 32'hAAAA_0002, 32'h0};
`endif
    check("t6_valid", bus.out_valid, 1);
    check("t6_data", bus.out_data, exp_data);
    check("t6_conflict", bus.tag_conflict, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
